// File: rtl/seven_seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seven_seg_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   localparam int unsigned DEF_TICK_DIV = 100000;
   localparam int unsigned DEF_HOLD_MS  = 2000;
   localparam int unsigned DIGIT_W      = 32;
   localparam int unsigned POINT_W      = 8;

   localparam logic [DIGIT_W-1:0] BLANK_WORD = 32'h0;

endpackage

// File: rtl/seven_seg_rr_pick.sv
// Round-robin selector: first requester searching cyclically from rr_last+1.
module seven_seg_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_last,
   output logic [IDX_W-1:0]   pick_c,
   output logic               any_req_c
);

   logic [IDX_W-1:0] idx;

   // rr_last itself is the last candidate visited, so a lone requester can re-win
   always_comb begin
      pick_c    = '0;
      any_req_c = 1'b0;
      idx       = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((32'(rr_last) + i) % NUM_REQ);
         if (!any_req_c && req[idx]) begin
            any_req_c = 1'b1;
            pick_c    = idx;
         end
      end
   end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Shares one 8-digit seven-segment scanner between NUM_REQ clients with
// round-robin grant, a minimum contended hold time and a blank gap between owners.
module seven_seg_display_arbiter
   import seven_seg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned TICK_DIV = DEF_TICK_DIV,
   parameter int unsigned HOLD_MS  = DEF_HOLD_MS
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [DIGIT_W*NUM_REQ-1:0]   req_digits,
   input  logic [POINT_W*NUM_REQ-1:0]   req_points,
   output logic [NUM_REQ-1:0]           grant,
   output logic [DIGIT_W-1:0]           disp_number,
   output logic [POINT_W-1:0]           dec_points,
   output logic                         blank
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_MS + 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_last_q, rr_last_d;
   logic [PRE_W-1:0]    prescaler_q, prescaler_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                hold_done_q, hold_done_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [DIGIT_W-1:0]  disp_q, disp_d;
   logic [POINT_W-1:0]  points_q, points_d;
   logic                blank_q, blank_d;

   logic [IDX_W-1:0]    pick_c;
   logic                any_req_c;
   logic                wrap_c;
   logic                hold_set_c;
   logic                expire_c;
   logic                release_c;
   logic                others_c;

   logic [DIGIT_W-1:0]  digits_a [NUM_REQ];
   logic [POINT_W-1:0]  points_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign digits_a[g] = req_digits[g*DIGIT_W +: DIGIT_W];
      assign points_a[g] = req_points[g*POINT_W +: POINT_W];
   end

   seven_seg_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req       (req),
      .rr_last   (rr_last_q),
      .pick_c    (pick_c),
      .any_req_c (any_req_c)
   );

   // In OWNED, rr_last_q is the owner and grant_q is its one-hot mask
   assign release_c  = ~|(req & grant_q);
   assign others_c   = |(req & ~grant_q);
   assign wrap_c     = (prescaler_q == PRE_W'(TICK_DIV - 1));
   assign hold_set_c = wrap_c && (hold_cnt_q == HOLD_W'(HOLD_MS - 1));
   // Expiry is seen on the same edge the last tick completes, giving exactly HOLD_MS*TICK_DIV cycles
   assign expire_c   = hold_done_q | hold_set_c;

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      prescaler_d = prescaler_q;
      hold_cnt_d  = hold_cnt_q;
      hold_done_d = hold_done_q;
      grant_d     = grant_q;
      disp_d      = disp_q;
      points_d    = points_q;
      blank_d     = blank_q;

      unique case (state_q)
         ST_IDLE, ST_GAP: begin
            if (any_req_c) begin
               state_d         = ST_OWNED;
               rr_last_d       = pick_c;
               prescaler_d     = '0;
               hold_cnt_d      = '0;
               hold_done_d     = 1'b0;
               grant_d         = '0;
               grant_d[pick_c] = 1'b1;
               blank_d         = 1'b0;
               disp_d          = digits_a[pick_c];
               points_d        = points_a[pick_c];
            end else begin
               state_d = ST_IDLE;
               grant_d = '0;
               blank_d = 1'b1;
            end
         end

         ST_OWNED: begin
            if (release_c || (expire_c && others_c)) begin
               state_d = ST_GAP;
               grant_d = '0;
               blank_d = 1'b1;
            end else begin
               disp_d      = digits_a[rr_last_q];
               points_d    = points_a[rr_last_q];
               prescaler_d = wrap_c ? '0 : prescaler_q + PRE_W'(1);
               if (wrap_c && !hold_done_q) begin
                  hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                  hold_done_d = hold_set_c;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            blank_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rr_last_q   <= IDX_W'(NUM_REQ - 1);
         prescaler_q <= '0;
         hold_cnt_q  <= '0;
         hold_done_q <= 1'b0;
         grant_q     <= '0;
         disp_q      <= BLANK_WORD;
         points_q    <= '0;
         blank_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         prescaler_q <= prescaler_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_done_q <= hold_done_d;
         grant_q     <= grant_d;
         disp_q      <= disp_d;
         points_q    <= points_d;
         blank_q     <= blank_d;
      end
   end

   assign grant       = grant_q;
   assign disp_number = disp_q;
   assign dec_points  = points_q;
   assign blank       = blank_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Self-checking bench: directed ownership scenarios plus random traffic against a cycle-count model.
module tb_seven_seg_display_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned TD    = 4;
   localparam int unsigned HM    = 3;
   localparam int unsigned LIMIT = TD * HM;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic [N-1:0]       req;
   logic [32*N-1:0]    req_digits;
   logic [8*N-1:0]     req_points;
   logic [N-1:0]       grant;
   logic [31:0]        disp_number;
   logic [7:0]         dec_points;
   logic               blank;

   int errors = 0;
   int checks = 0;

   // Reference model: owner index (-1 none), gap flag, cycles the owner has been on screen
   int           m_owner;
   bit           m_gap;
   int           m_owned;
   int           m_rr;
   logic [N-1:0] m_grant;
   logic [31:0]  m_disp;
   logic [7:0]   m_pts;
   logic         m_blank;

   always #5 clock = ~clock;

   seven_seg_display_arbiter #(
      .NUM_REQ  (N),
      .TICK_DIV (TD),
      .HOLD_MS  (HM)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req         (req),
      .req_digits  (req_digits),
      .req_points  (req_points),
      .grant       (grant),
      .disp_number (disp_number),
      .dec_points  (dec_points),
      .blank       (blank)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_gap   = 1'b0;
      m_owned = 0;
      m_rr    = N - 1;
      m_grant = '0;
      m_disp  = 32'h0;
      m_pts   = 8'h0;
      m_blank = 1'b1;
   endtask

   task automatic model_step();
      int pick;
      logic [N-1:0] others;
      if (m_owner < 0 || m_gap) begin
         pick = -1;
         for (int k = 1; k <= N; k++)
            if (pick < 0 && req[(m_rr + k) % N]) pick = (m_rr + k) % N;
         m_gap = 1'b0;
         if (pick >= 0) begin
            m_owner = pick;
            m_rr    = pick;
            m_owned = 1;
            m_grant = N'(1) << pick;
            m_blank = 1'b0;
            m_disp  = req_digits[32*pick +: 32];
            m_pts   = req_points[8*pick +: 8];
         end else begin
            m_owner = -1;
            m_grant = '0;
            m_blank = 1'b1;
         end
      end else begin
         others = req;
         others[m_owner] = 1'b0;
         if (!req[m_owner] || (m_owned >= LIMIT && others != '0)) begin
            m_gap   = 1'b1;
            m_grant = '0;
            m_blank = 1'b1;
         end else begin
            if (m_owned < LIMIT) m_owned++;
            m_disp = req_digits[32*m_owner +: 32];
            m_pts  = req_points[8*m_owner +: 8];
         end
      end
   endtask

   task automatic check_outputs(input string pfx);
      check_eq({pfx, ".grant"}, 32'(grant), 32'(m_grant));
      check_eq({pfx, ".blank"}, 32'(blank), 32'(m_blank));
      check_eq({pfx, ".disp"},  disp_number, m_disp);
      check_eq({pfx, ".dp"},    32'(dec_points), 32'(m_pts));
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge
   task automatic cycle(input string pfx);
      @(posedge clock);
      if (reset_n) model_step();
      @(negedge clock);
      check_outputs(pfx);
   endtask

   // Async reset pulse dropped mid-cycle and checked before the next rising edge
   task automatic do_reset();
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_outputs("async_rst");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int cnt;
      int k;
      req = '0;
      for (int i = 0; i < N; i++) begin
         req_digits[32*i +: 32] = 32'h1111_1111 * (i + 1);
         req_points[8*i +: 8]   = 8'h01 << i;
      end
      model_reset();

      // Reset state
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      check_outputs("reset");
      cycle("idle");

      // Single client grant then release into one gap and idle
      req = 4'b0001;
      cycle("own0");
      check_eq("own0_disp", disp_number, 32'h1111_1111);
      check_eq("own0_dp", 32'(dec_points), 32'h01);
      repeat (4) cycle("own0_hold");
      req = '0;
      cycle("rel_gap");
      check_eq("gap_blank", 32'(blank), 32'h1);
      check_eq("gap_disp_held", disp_number, 32'h1111_1111);
      cycle("rel_idle");

      // Two contenders: exactly LIMIT cycles each, then alternate
      do_reset();
      req = 4'b0011;
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
         cycle("rr01");
         if (grant == 4'b0001) cnt++;
      end
      check_eq("hold_len0", 32'(cnt), 32'd12);
      check_eq("rr_to1", 32'(grant), 32'b0010);
      check_eq("rr_to1_disp", disp_number, 32'h2222_2222);
      repeat (13) cycle("rr10");
      check_eq("rr_back0", 32'(grant), 32'b0001);

      // Late contender waits out the hold window from the grant start
      do_reset();
      req = 4'b0001;
      cnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (c == 2) req = 4'b0101;
         cycle("late");
         if (grant == 4'b0001) cnt++;
      end
      check_eq("late_hold_len", 32'(cnt), 32'd12);
      check_eq("late_to2", 32'(grant), 32'b0100);

      // Lone requester keeps the display indefinitely, data tracks with one cycle latency
      do_reset();
      req = 4'b1000;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         cycle("lone");
         if (grant != 4'b1000) cnt++;
      end
      check_eq("lone_no_gap", 32'(cnt), 32'd0);
      req_digits[96 +: 32] = 32'hDEAD_BEEF;
      cycle("lone_upd");
      check_eq("lone_upd_disp", disp_number, 32'hDEAD_BEEF);

      // Release coinciding with expiry: one gap, then round robin from 1 skips 0
      do_reset();
      req = 4'b0010;
      cycle("exp1");
      req = 4'b0111;
      repeat (11) cycle("exp1_hold");
      check_eq("exp1_still", 32'(grant), 32'b0010);
      req = 4'b0101;
      cycle("exp1_gap");
      check_eq("exp1_gap_grant", 32'(grant), 32'b0000);
      cycle("exp1_next");
      check_eq("exp1_next_grant", 32'(grant), 32'b0100);

      // Random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, N - 1);
            req[k] = ~req[k];
         end
         if ($urandom_range(0, 15) == 0) begin
            k = $urandom_range(0, N - 1);
            req_digits[32*k +: 32] = $urandom;
            req_points[8*k +: 8]   = 8'($urandom);
         end
         if (c == 1500) do_reset();
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
Shares the single 8-digit seven-segment scanner (the 32-bit digit word plus 8 decimal-point inputs) between NUM_REQ display clients, e.g. stopwatch, countdown timer and mode banner. Uses a request/grant handshake, round-robin selection and a guaranteed minimum on-screen time per client. A one-cycle blank gap separates owners so there is no ghosting. It sits between the clients and the scanner and drives the scanner's digit word, decimal-point mask and a blank control.

Parameters:
NUM_REQ, 4, number of display clients (2..8)
TICK_DIV, 100000, clock cycles per 1 ms hold tick
HOLD_MS, 2000, minimum ms a granted client keeps the display while others wait (>=1)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  level request per client; held high while the client wants the display
req_digits  input  32*NUM_REQ  client i digit word in bits [32i+31:32i]; 8 nibbles, nibble 0 = rightmost digit
req_points  input  8*NUM_REQ  client i decimal-point mask in bits [8i+7:8i]
grant  output  NUM_REQ  one-hot owner; all zero when no owner
disp_number  output  32  digit word to scanner
dec_points  output  8  decimal-point mask to scanner
blank  output  1  1 = scanner must drive all anodes off

Behaviour:
- Reset (async, while reset_n=0): state=IDLE, grant=0, disp_number=0, dec_points=0, blank=1, rr_last=NUM_REQ-1, prescaler=0, hold_cnt=0, hold_done=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Round-robin pick: the first index with req high, searching cyclically from rr_last+1. It may return rr_last itself if that is the only requester.
- States:
  - IDLE: grant=0, blank=1. On an edge with any req high, go to OWNED with owner=pick. grant goes high on that same edge.
  - OWNED: grant=onehot(owner), blank=0. On every edge, disp_number <= req_digits[owner] and dec_points <= req_points[owner]. This includes the entering edge, so data is valid in the first grant cycle and then tracks the client with 1-cycle latency.
  - GAP: exactly one cycle. grant=0, blank=1, and disp_number/dec_points hold their last value. Next edge: if any req is high, go to OWNED with a new pick; otherwise go to IDLE.
- Entering OWNED sets rr_last=owner, prescaler=0, hold_cnt=0, hold_done=0.
- In OWNED, prescaler counts 0..TICK_DIV-1 and wraps. Each wrap increments hold_cnt. hold_done is set when hold_cnt reaches HOLD_MS, then stays set and hold_cnt stops (saturates).
- OWNED -> GAP when either condition holds:
  - req[owner]=0 (release; takes priority, ignores hold), or
  - hold_done=1 and some other req[j]=1 (j != owner).
- Otherwise OWNED persists. A lone requester keeps the display indefinitely, with no gap.
- Minimum ownership while contended = HOLD_MS*TICK_DIV cycles, then 1 GAP cycle.
- Simultaneous owner release and expiry: treat as release. Same GAP result.
- Requests that rise and fall while another client owns the display are not queued; only req high at pick time counts.
- reset_n low mid-ownership: immediately return to the reset values above. After reset, index 0 wins first.

Decomposition:
- Package seven_seg_arb_pkg: state encoding (IDLE, OWNED, GAP), defaults for TICK_DIV and HOLD_MS, and BLANK_WORD=32'h0.
- Sub-module seven_seg_rr_pick: combinational; inputs req and rr_last; outputs pick index and any_req.
- Prescaler and hold counter stay inline.

Test Plan (TICK_DIV=4, HOLD_MS=3, NUM_REQ=4; client i digits = 32'h1111_1111*(i+1), points = 8'h01<<i):
1. Assert then release reset_n with req=0 -> grant=0000, blank=1, disp_number=0, dec_points=0. Drop reset_n mid-OWNED -> outputs return to these values asynchronously, before the next edge.
2. req=0001 at edge k -> after edge k: grant=0001, blank=0, disp_number=32'h1111_1111, dec_points=8'h01. Drop req at edge m -> one GAP cycle (grant=0, blank=1, disp held) -> IDLE.
3. req=0011 from reset -> grant=0001 for exactly 12 cycles, 1 GAP cycle, then grant=0010 and disp_number=32'h2222_2222. With req still 0011, 12 cycles later the grant returns to 0001.
4. Owner 0 granted; req[2] rises 2 cycles later -> grant stays 0001 until 12 cycles from the start of the grant, then GAP, then grant=0100.
5. Only req[3] high for 40 cycles -> grant=1000 throughout, with no GAP. Change req_digits[3] to 32'hDEAD_BEEF -> disp_number updates 1 cycle later.
6. Owner 1 with req=0111; at the hold-expiry edge req[1] drops -> single GAP, then grant=0100 (round robin from 1 skips 0).
